// File: rtl/decoder_bcd_pkg.sv
// Shared widths, types and helpers for the BCD one-of-nine decoder.
// The decoded word packs the nine digit lines with the invalid flag.
package decoder_bcd_pkg;

  localparam int BCD_W     = 4;
  localparam int BCD_MAX   = 9;
  localparam int NUM_LINES = 9;

  typedef logic [BCD_W-1:0]     bcd_code_t;
  typedef logic [NUM_LINES-1:0] lines_t;

  // lines[0] drives d1, lines[8] drives d9
  typedef struct packed {
    logic   invalid;
    lines_t lines;
  } decode_t;

  function automatic logic is_bcd(input bcd_code_t code);
    return code <= bcd_code_t'(BCD_MAX);
  endfunction

endpackage

// File: rtl/decoder_bcd_onehot_comb.sv
// Purely combinational BCD code to one-hot digit lines plus invalid flag.
// Code 0 and codes 10..15 leave every line low; only 10..15 flag invalid.
module decoder_bcd_onehot_comb
  import decoder_bcd_pkg::*;
(
  input  logic [BCD_W-1:0]     code,
  output logic [NUM_LINES-1:0] lines,
  output logic                 invalid
);

  logic code_ok;

  assign code_ok = is_bcd(code);

  always_comb begin
    lines   = '0;
    invalid = ~code_ok;
    if (code_ok && (code != '0)) begin
      lines = lines_t'(1) << (code - bcd_code_t'(1));
    end
  end

endmodule

// File: rtl/decoder_bcd.sv
// BCD-to-one-of-nine decoder with an optional output register stage.
// REG_OUT=1 gives one cycle of latency and async clear; REG_OUT=0 is pure logic.
module decoder_bcd
  import decoder_bcd_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7,
  output logic d8,
  output logic d9,
  output logic invalid
);

  bcd_code_t code;
  decode_t   dec_c;
  decode_t   dec_o;

  assign code = {a, b, c, d};

  decoder_bcd_onehot_comb u_onehot (
    .code    (code),
    .lines   (dec_c.lines),
    .invalid (dec_c.invalid)
  );

  generate
    if (REG_OUT) begin : g_reg
      decode_t dec_q;

      // The whole word clears together, so no stale line survives a reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dec_q <= '0;
        end else begin
          dec_q <= dec_c;
        end
      end

      assign dec_o = dec_q;
    end else begin : g_comb
      logic unused_clk_rst;

      assign unused_clk_rst = &{1'b0, clk, rst_n};
      assign dec_o          = dec_c;
    end
  endgenerate

  assign d1      = dec_o.lines[0];
  assign d2      = dec_o.lines[1];
  assign d3      = dec_o.lines[2];
  assign d4      = dec_o.lines[3];
  assign d5      = dec_o.lines[4];
  assign d6      = dec_o.lines[5];
  assign d7      = dec_o.lines[6];
  assign d8      = dec_o.lines[7];
  assign d9      = dec_o.lines[8];
  assign invalid = dec_o.invalid;

endmodule

// File: tb/tb_decoder_bcd.sv
// Self-checking bench for decoder_bcd: registered and combinational variants
// driven from the same inputs and compared against a code-level reference.
module tb_decoder_bcd;

  logic clk;
  logic rst_n;
  logic a, b, c, d;

  logic r1, r2, r3, r4, r5, r6, r7, r8, r9, r_inv;
  logic c1, c2, c3, c4, c5, c6, c7, c8, c9, c_inv;

  int checks;
  int errors;
  bit chk_en;

  // reference state: code captured on the last edge, and whether one was captured
  int prev_code;
  bit have_code;

  // {invalid, d9..d1} per code, written out by hand
  logic [9:0] sweep_exp [16];

  decoder_bcd #(.REG_OUT(1'b1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .d1(r1), .d2(r2), .d3(r3), .d4(r4), .d5(r5), .d6(r6), .d7(r7), .d8(r8), .d9(r9),
    .invalid(r_inv)
  );

  decoder_bcd #(.REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .d1(c1), .d2(c2), .d3(c3), .d4(c4), .d5(c5), .d6(c6), .d7(c7), .d8(c8), .d9(c9),
    .invalid(c_inv)
  );

  wire [9:0] reg_v  = {r_inv, r9, r8, r7, r6, r5, r4, r3, r2, r1};
  wire [9:0] comb_v = {c_inv, c9, c8, c7, c6, c5, c4, c3, c2, c1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ref_decode(input int code);
    logic [9:0] r;
    r = '0;
    if (code >= 1 && code <= 9) r[code-1] = 1'b1;
    else if (code >= 10) r[9] = 1'b1;
    return r;
  endfunction

  function automatic int cur_code();
    return int'({a, b, c, d});
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_code(input int code);
    {a, b, c, d} = 4'(code);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_code <= 1'b0;
    end else begin
      have_code <= 1'b1;
      prev_code <= cur_code();
    end
  end

  // per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_model", reg_v, have_code ? ref_decode(prev_code) : 10'h000);
      chk("comb_model", comb_v, ref_decode(cur_code()));
      checks++;
      if ($countones(reg_v) > 1 || $countones(comb_v) > 1) begin
        errors++;
        $display("FAIL onehot reg=%h comb=%h at %0t", reg_v, comb_v, $time);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    prev_code = 0;
    sweep_exp = '{10'h000, 10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                  10'h040, 10'h080, 10'h100, 10'h200, 10'h200, 10'h200, 10'h200,
                  10'h200, 10'h200};

    // model pinned by literals
    chk("ref_pin_0", ref_decode(0), 10'h000);
    chk("ref_pin_5", ref_decode(5), 10'h010);
    chk("ref_pin_13", ref_decode(13), 10'h200);

    // reset held with code 5 applied
    rst_n = 1'b0;
    set_code(5);
    #1;
    chk_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_hold", reg_v, 10'h000);
    end
    #1 rst_n = 1'b1;
    #1 chk("reset_release_no_edge", reg_v, 10'h000);
    @(posedge clk); #1;
    chk("reset_first_d5", reg_v, 10'h010);

    // full sweep, one code per cycle
    #1;
    for (int i = 0; i < 16; i++) begin
      set_code(i);
      @(posedge clk); #1;
      chk($sformatf("sweep_%0d", i), reg_v, sweep_exp[i]);
      #1;
    end

    // latency: 3 -> 7 between edges
    set_code(3);
    @(posedge clk); #1;
    chk("lat_d3", reg_v, 10'h004);
    #1 set_code(7);
    #3 chk("lat_hold_d3", reg_v, 10'h004);
    @(posedge clk); #1;
    chk("lat_d7", reg_v, 10'h040);

    // mid-operation async reset with d9 high
    #1 set_code(9);
    @(posedge clk); #1;
    chk("mid_d9", reg_v, 10'h100);
    #1 rst_n = 1'b0;
    #1 chk("mid_async_clear", reg_v, 10'h000);
    #4 rst_n = 1'b1;
    #1 chk("mid_after_release", reg_v, 10'h000);
    @(posedge clk); #1;
    chk("mid_restore_d9", reg_v, 10'h100);

    // combinational variant: 50 ns steps, rst_n toggled inside each step
    #1;
    for (int i = 0; i < 16; i++) begin
      set_code(i);
      #1 chk($sformatf("comb_sweep_%0d", i), comb_v, sweep_exp[i]);
      #24 rst_n = 1'b0;
      #1 chk($sformatf("comb_rst_%0d", i), comb_v, sweep_exp[i]);
      #10 rst_n = 1'b1;
      #14;
    end

    // random stimulus, sometimes with a second change between edges
    @(posedge clk); #2;
    for (int n = 0; n < 1000; n++) begin
      set_code(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        #5 set_code(int'($urandom_range(0, 15)));
        #5;
      end else begin
        #10;
      end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_bcd.md
Name: decoder_bcd

Overview:
- Registered BCD-to-one-of-nine decoder. Converts a 4-bit BCD digit, supplied as four separate bit inputs (a = MSB … d = LSB), into nine active-high one-hot lines d1..d9.
- Digit 0 and the non-BCD codes 10-15 drive no line; the non-BCD codes also raise an error flag.
- Sits between digit-generation logic and per-digit consumers (indicators, enables).

Parameters:
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational from a,b,c,d (clk/rst_n unused).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  1  BCD bit 3 (MSB, weight 8)
- b  input  1  BCD bit 2 (weight 4)
- c  input  1  BCD bit 1 (weight 2)
- d  input  1  BCD bit 0 (LSB, weight 1)
- d1..d9  output  1 each  one-hot digit lines; dN high iff the code equals N
- invalid  output  1  high iff the code is 10..15

Interface decisions:
- One clock; reset is asynchronous and active-low, named clk and rst_n.

Behaviour:
- Code formation: code = {a,b,c,d}, unsigned 0..15.
- Decode rule: dN = (code == N) for N = 1..9.
- Code 0: all d1..d9 = 0, invalid = 0. There is no d0 line.
- Codes 10..15: all d1..d9 = 0, invalid = 1.
- Output invariant: at most one of d1..d9 is high at any time. invalid is never high together with any dN.
- REG_OUT=1, latency:
  - Inputs are sampled on the rising edge of clk.
  - Outputs reflect the code sampled on the previous edge (latency exactly 1 cycle).
  - Outputs are held constant between edges.
- REG_OUT=1, reset:
  - While rst_n = 0, all of d1..d9 and invalid are 0, asynchronously and independent of clk.
  - First valid output appears on the first rising edge after rst_n deasserts.
  - rst_n asserted mid-stream clears outputs immediately, with no glitch to a stale value.
- REG_OUT=0:
  - Outputs follow inputs combinationally, with zero latency.
  - Reset has no effect.
- Input changes between edges (REG_OUT=1): only the value present at the edge matters; no intermediate codes appear on outputs.
- X/Z on inputs: no requirement; the bench drives only 0/1.
- No internal state beyond the output register bank (10 flops).

Decomposition:
- Package decoder_bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 9
  - NUM_LINES = 9
  - function is_bcd(code) returning code <= BCD_MAX
- Optional combinational sub-module bcd_onehot_comb: code in, 9-bit one-hot plus invalid out. decoder_bcd wraps it with the REG_OUT-selected register stage.

Test Plan:
- Reset: hold rst_n=0 with code 5 applied for 3 cycles -> d1..d9 = 0, invalid = 0 throughout. Release rst_n -> d5 = 1 after the next rising edge.
- Full sweep (REG_OUT=1): apply codes 0..15, one per cycle (a toggling slowest, d fastest) -> one cycle later:
  - code 0: all lines 0
  - code N in 1..9: only dN = 1
  - codes 10..15: all lines 0 and invalid = 1
- Latency: change code 3 -> 7 between edges -> d3 stays high until the next edge, then d7 = 1 and d3 = 0 on that same edge.
- Mid-operation reset: with d9 = 1, pulse rst_n low for half a cycle -> d9 drops immediately (asynchronously). After release, the next edge restores the decode of the current input.
- Combinational variant (REG_OUT=0): sweep 0..15 with 50 ns steps -> outputs match the decode rule within the same step. Toggling rst_n has no effect.
- One-hot invariant: random 1000-cycle stimulus -> every cycle, popcount(d1..d9) + invalid <= 1, and outputs match a reference model of the previous-cycle code.
